// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/exec/mem/writeback control FSM
//
// Purpose:
//   Sequences one instruction at a time through FETCH -> DECODE -> EXEC ->
//   (MEM) -> WB, owns the PC and the retired-instruction counter, drives the
//   instruction/data memory request handshakes and produces one-cycle
//   enables for the IR, register file and PC. Faults park the FSM in HALT,
//   which only reset leaves.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   dec_mem_rd/_wr/_reg_wr/_branch   decoder control for the current instruction
//   dec_illegal                      decoder: unsupported opcode
//   branch_taken, branch_target      branch outcome and target from datapath
//   imem_req / imem_ack              instruction fetch handshake (addr = pc)
//   dmem_req / dmem_we / dmem_ack    data access handshake
//   ir_load, rf_we                   one-cycle IR latch / register write strobes
//   pc, retired                      current PC, completed-instruction count
//   halted, fault, state_dbg         halt flag, fault code, encoded state

module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_mem_rd,
  input  logic             dec_mem_wr,
  input  logic             dec_reg_wr,
  input  logic             dec_branch,
  input  logic             dec_illegal,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_load,
  output logic             rf_we,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] F_NONE    = 2'd0;
  localparam logic [1:0] F_ILLEGAL = 2'd1;
  localparam logic [1:0] F_TIMEOUT = 2'd2;
  localparam logic [1:0] F_MISALGN = 2'd3;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [1:0]        fault_q, fault_d;
  logic [31:0]       tmo_q, tmo_d;

  logic imem_req_c, dmem_req_c, dmem_we_c, ir_load_c, rf_we_c;
  logic tmo_expire;
  logic take_branch;

  // Last allowed request cycle: an ack in this cycle still wins.
  assign tmo_expire  = (TIMEOUT != 0) && (tmo_q == TIMEOUT - 1);
  assign take_branch = dec_branch & branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      fault_q   <= F_NONE;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    fault_d    = fault_q;
    tmo_d      = tmo_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_load_c  = 1'b0;
    rf_we_c    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_load_c = 1'b1;
          state_d   = S_DECODE;
        end else if (tmo_expire) begin
          state_d = S_HALT;
          fault_d = F_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_HALT;
          fault_d = F_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (dec_mem_rd | dec_mem_wr) begin
          state_d = S_MEM;
          tmo_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = dec_mem_wr;
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (tmo_expire) begin
          state_d = S_HALT;
          fault_d = F_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      S_WB: begin
        if (take_branch && (branch_target[1:0] != 2'b00)) begin
          // Misaligned target: the instruction does not retire.
          state_d = S_HALT;
          fault_d = F_MISALGN;
        end else begin
          rf_we_c   = dec_reg_wr;
          pc_d      = take_branch ? branch_target : pc_q + 32'd4;
          retired_d = retired_q + CNT_W'(1);
          tmo_d     = '0;
          state_d   = S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low for the whole reset cycle so an abandoned
  // request never leaks out while the state register is being cleared.
  assign imem_req  = imem_req_c & ~reset;
  assign dmem_req  = dmem_req_c & ~reset;
  assign dmem_we   = dmem_we_c  & ~reset;
  assign ir_load   = ir_load_c  & ~reset;
  assign rf_we     = rf_we_c    & ~reset;

  assign pc        = pc_q;
  assign retired   = retired_q;
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int TMO = 16;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRT = 3, K_BRN = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_mem_rd = 0, dec_mem_wr = 0, dec_reg_wr = 0, dec_branch = 0, dec_illegal = 0;
  logic        branch_taken = 0;
  logic [31:0] branch_target = '0;
  logic        imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0;
  logic        ir_load, rf_we, halted;
  logic [31:0] pc, retired;
  logic [1:0]  fault;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] pc_m;
  logic [31:0] ret_m;

  multicycle_ctrl #(.RESET_PC(RPC), .TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_wr(dec_reg_wr),
    .dec_branch(dec_branch), .dec_illegal(dec_illegal),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_load(ir_load), .rf_we(rf_we), .pc(pc), .retired(retired),
    .halted(halted), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 0; dmem_ack = 0;
    {dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_branch, dec_illegal, branch_taken} = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({imem_req, dmem_req, ir_load, rf_we} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_strobes: got %b exp 0000", {imem_req, dmem_req, ir_load, rf_we});
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (state_dbg !== 3'd0 || pc !== RPC || retired !== 32'd0 || fault !== 2'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: st=%0d pc=%h ret=%0d fault=%0d halted=%b exp 0 %h 0 0 0",
               state_dbg, pc, retired, fault, halted, RPC);
    end
    n_checks++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_fetch: imem_req=%b dmem_req=%b exp 1 0", imem_req, dmem_req);
    end
    pc_m = RPC;
    ret_m = 0;
  endtask

  // Runs one instruction from the first FETCH cycle. fw/dw are wait cycles
  // before the ack; a value >= TMO means the ack never comes.
  task automatic run_instr(input int kind, input int fw, input int dw,
                           input bit reg_wr, input logic [31:0] tgt);
    int cyc, st, flt, imem_exp, dmem_exp, we_exp, ir_exp, rf_exp;
    int ni, nd, nw, nir, nrf, both;
    bit is_mem, taken;
    logic [31:0] pc_exp, ret_exp;

    dec_mem_rd    = (kind == K_LOAD);
    dec_mem_wr    = (kind == K_STORE);
    dec_reg_wr    = reg_wr;
    dec_branch    = (kind == K_BRT) || (kind == K_BRN);
    branch_taken  = (kind == K_BRT);
    dec_illegal   = (kind == K_ILL);
    branch_target = tgt;

    is_mem  = (kind == K_LOAD) || (kind == K_STORE);
    taken   = (kind == K_BRT);
    pc_exp  = pc_m;
    ret_exp = ret_m;
    st = 5; ir_exp = 1; rf_exp = 0; dmem_exp = 0;
    if (fw >= TMO) begin
      cyc = TMO; flt = 2; imem_exp = TMO; ir_exp = 0;
    end else if (kind == K_ILL) begin
      cyc = fw + 2; flt = 1; imem_exp = fw + 1;
    end else if (is_mem && dw >= TMO) begin
      cyc = fw + 3 + TMO; flt = 2; imem_exp = fw + 1; dmem_exp = TMO;
    end else begin
      imem_exp = fw + 1;
      dmem_exp = is_mem ? dw + 1 : 0;
      cyc = 4 + fw + dmem_exp;
      if (taken && tgt[1:0] != 2'b00) begin
        flt = 3;
      end else begin
        st = 0; flt = 0; rf_exp = reg_wr;
        pc_exp = taken ? tgt : pc_m + 32'd4;
        ret_exp = ret_m + 32'd1;
      end
    end
    we_exp = (kind == K_STORE) ? dmem_exp : 0;

    ni = 0; nd = 0; nw = 0; nir = 0; nrf = 0; both = 0;
    for (int c = 0; c < cyc; c++) begin
      imem_ack = 0; dmem_ack = 0;
      #1;
      if (imem_req) begin
        if (ni == fw) imem_ack = 1;
        ni++;
      end
      if (dmem_req) begin
        if (nd == dw) dmem_ack = 1;
        nd++;
        if (dmem_we) nw++;
      end
      if (imem_req && dmem_req) both++;
      #1;
      if (ir_load) nir++;
      if (rf_we) nrf++;
      @(negedge clk);
    end
    imem_ack = 0; dmem_ack = 0;
    #1;

    n_checks++;
    if (state_dbg !== 3'(st) || fault !== 2'(flt) || halted !== (st == 5)) begin
      n_fail++;
      $display("FAIL end_state k=%0d fw=%0d dw=%0d: st=%0d fault=%0d halted=%b exp %0d %0d",
               kind, fw, dw, state_dbg, fault, halted, st, flt);
    end
    n_checks++;
    if (pc !== pc_exp || retired !== ret_exp) begin
      n_fail++;
      $display("FAIL pc_retired k=%0d: pc=%h ret=%0d exp %h %0d", kind, pc, retired, pc_exp, ret_exp);
    end
    n_checks++;
    if (ni != imem_exp || nd != dmem_exp || nw != we_exp) begin
      n_fail++;
      $display("FAIL req_counts k=%0d: imem=%0d dmem=%0d we=%0d exp %0d %0d %0d",
               kind, ni, nd, nw, imem_exp, dmem_exp, we_exp);
    end
    n_checks++;
    if (nir != ir_exp || nrf != rf_exp || both != 0) begin
      n_fail++;
      $display("FAIL pulses k=%0d: ir_load=%0d rf_we=%0d both_req=%0d exp %0d %0d 0",
               kind, nir, nrf, both, ir_exp, rf_exp);
    end
    pc_m = pc_exp;
    ret_m = ret_exp;
  endtask

  task automatic test_alu_basic();
    run_instr(K_ALU, 0, 0, 1'b1, 32'h0);
  endtask

  task automatic test_load_store();
    run_instr(K_LOAD, 0, 3, 1'b1, 32'h0);
    run_instr(K_STORE, 1, 2, 1'b0, 32'h0);
  endtask

  task automatic test_branches();
    run_instr(K_BRT, 0, 0, 1'b0, 32'h0000_0040);
    run_instr(K_BRN, 2, 0, 1'b0, 32'h0000_0080);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [31:0] t;
      k = $urandom_range(0, 4);
      t = $urandom & 32'hFFFF_FFFC;
      run_instr(k, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), t);
    end
  endtask

  task automatic test_ack_last_cycle();
    test_reset();
    run_instr(K_ALU, TMO - 1, 0, 1'b1, 32'h0);
    run_instr(K_LOAD, 0, TMO - 1, 1'b1, 32'h0);
  endtask

  // Each variant halts; afterwards strobes stay low and state holds even
  // with stray acks driven.
  task automatic test_halt_cases();
    for (int v = 0; v < 4; v++) begin
      logic [1:0] f;
      test_reset();
      run_instr(K_ALU, $urandom_range(0, 2), 0, 1'b1, 32'h0);
      case (v)
        0: run_instr(K_BRT, 0, 0, 1'b1, 32'h0000_0042);
        1: run_instr(K_ILL, 1, 0, 1'b1, 32'h0);
        2: run_instr(K_ALU, TMO, 0, 1'b1, 32'h0);
        default: run_instr(K_STORE, 0, TMO, 1'b0, 32'h0);
      endcase
      f = (v == 0) ? 2'd3 : (v == 1) ? 2'd1 : 2'd2;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        imem_ack = 1; dmem_ack = 1;
        #1;
        n_checks++;
        if ({imem_req, dmem_req, ir_load, rf_we} !== 4'b0 || halted !== 1'b1 ||
            pc !== pc_m || retired !== ret_m || fault !== f) begin
          n_fail++;
          $display("FAIL halt_hold v=%0d: strobes=%b halted=%b pc=%h ret=%0d fault=%0d exp 0000 1 %h %0d %0d",
                   v, {imem_req, dmem_req, ir_load, rf_we}, halted, pc, retired, fault, pc_m, ret_m, f);
        end
      end
      imem_ack = 0; dmem_ack = 0;
    end
  endtask

  task automatic test_reset_mid_mem();
    test_reset();
    run_instr(K_ALU, 0, 0, 1'b1, 32'h0);
    run_instr(K_ALU, 1, 0, 1'b1, 32'h0);
    dec_mem_rd = 1; dec_mem_wr = 0; dec_reg_wr = 1; dec_branch = 0; dec_illegal = 0;
    // FETCH acked at once, then DECODE, EXEC and two MEM cycles with no ack.
    for (int c = 0; c < 5; c++) begin
      imem_ack = (c == 0); dmem_ack = 0;
      @(negedge clk);
    end
    imem_ack = 0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b1 || state_dbg !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_mem_reach: dmem_req=%b st=%0d exp 1 3", dmem_req, state_dbg);
    end
    @(negedge clk);
    reset = 1;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_mem_reset_strobes: dmem_req=%b imem_req=%b exp 0 0", dmem_req, imem_req);
    end
    @(negedge clk);
    reset = 0;
    dmem_ack = 1;
    #1;
    n_checks++;
    if (state_dbg !== 3'd0 || pc !== RPC || retired !== 32'd0 || dmem_req !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mem_after_reset: st=%0d pc=%h ret=%0d dmem_req=%b imem_req=%b exp 0 %h 0 0 1",
               state_dbg, pc, retired, dmem_req, imem_req, RPC);
    end
    @(negedge clk);
    dmem_ack = 0;
    #1;
    n_checks++;
    if (state_dbg !== 3'd0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL late_ack_ignored: st=%0d imem_req=%b exp 0 1", state_dbg, imem_req);
    end
    pc_m = RPC;
    ret_m = 0;
    run_instr(K_ALU, 0, 0, 1'b1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_load_store();
    test_branches();
    test_back_to_back();
    test_ack_last_cycle();
    test_halt_cases();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
